// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: timekeeping and time-set controller for the digital clock.
// Turns the divider's 1/4/64 Hz square waves into single-cycle ticks, runs the
// hh:mm:ss counters, and sequences RUN / SET_HR / SET_MIN with two buttons.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   i_clk1     1 Hz square wave
//   i_clk4     4 Hz square wave (blink phase, hold timing)
//   i_clk64    64 Hz square wave (auto-repeat rate)
//   btn_mode   debounced mode button (level)
//   btn_inc    debounced increment button (level)
//   hours      0..23 binary, registered
//   minutes    0..59 binary, registered
//   seconds    0..59 binary, registered
//   mode       00 RUN, 01 SET_HR, 10 SET_MIN, registered
//   blank_hr   hour-digit blanking, combinational from registered state
//   blank_min  minute-digit blanking, combinational from registered state
module clock_time_ctrl #(
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned REPEAT_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clk1,
  input  logic       i_clk4,
  input  logic       i_clk64,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min
);

  localparam int unsigned HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam int unsigned REP_W  = (REPEAT_DIV < 2) ? 1 : $clog2(REPEAT_DIV);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t state;

  logic armed;
  logic clk1_d, clk4_d, clk64_d, mode_d, inc_d;
  logic tick1, tick4, tick64, mode_press, inc_press;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic blink_ph;
  logic hold_sat, rep_wrap, rep_fire, inc_req;

  // Edge-detect delay registers. 'armed' masks the first clock after reset so
  // an input already high at release only loads its _d register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      clk1_d  <= 1'b0;
      clk4_d  <= 1'b0;
      clk64_d <= 1'b0;
      mode_d  <= 1'b0;
      inc_d   <= 1'b0;
    end else begin
      armed   <= 1'b1;
      clk1_d  <= i_clk1;
      clk4_d  <= i_clk4;
      clk64_d <= i_clk64;
      mode_d  <= btn_mode;
      inc_d   <= btn_inc;
    end
  end

  assign tick1      = armed & i_clk1   & ~clk1_d;
  assign tick4      = armed & i_clk4   & ~clk4_d;
  assign tick64     = armed & i_clk64  & ~clk64_d;
  assign mode_press = armed & btn_mode & ~mode_d;
  assign inc_press  = armed & btn_inc  & ~inc_d;

  // Auto-repeat: qualify on the live btn_inc level so release stops at once.
  assign hold_sat = (hold_cnt == HOLD_W'(HOLD_TICKS));
  assign rep_wrap = (rep_cnt == REP_W'(REPEAT_DIV - 1));
  assign rep_fire = btn_inc & hold_sat & tick64 & rep_wrap;
  assign inc_req  = ~mode_press & (inc_press | rep_fire);

  // Hold and repeat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (!btn_inc || mode_press) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      if (tick4 && !hold_sat) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      if (hold_sat && tick64) begin
        rep_cnt <= rep_wrap ? '0 : rep_cnt + REP_W'(1);
      end
    end
  end

  // 2 Hz blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_ph <= 1'b0;
    end else if (tick4) begin
      blink_ph <= ~blink_ph;
    end
  end

  // Mode FSM and time counters; mode press always takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mode_press) begin
            state   <= SET_HR;
            seconds <= '0;
          end else if (tick1) begin
            if (seconds == 6'd59) begin
              seconds <= '0;
              if (minutes == 6'd59) begin
                minutes <= '0;
                hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
              end else begin
                minutes <= minutes + 6'd1;
              end
            end else begin
              seconds <= seconds + 6'd1;
            end
          end
        end
        SET_HR: begin
          if (mode_press) begin
            state <= SET_MIN;
          end else if (inc_req) begin
            hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
          end
        end
        SET_MIN: begin
          if (mode_press) begin
            state <= RUN;
          end else if (inc_req) begin
            minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign mode      = state;
  assign blank_hr  = (state == SET_HR)  & blink_ph & ~btn_inc;
  assign blank_min = (state == SET_MIN) & blink_ph & ~btn_inc;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed, table-driven bench for clock_time_ctrl.
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_clk1, i_clk4, i_clk64, btn_mode, btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [1:0] mode;
  logic       blank_hr, blank_min;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_time_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .i_clk1    (i_clk1),
    .i_clk4    (i_clk4),
    .i_clk64   (i_clk64),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds),
    .mode      (mode),
    .blank_hr  (blank_hr),
    .blank_min (blank_min)
  );

  typedef enum int {OP_T1, OP_T4, OP_MODE, OP_INC} op_t;
  typedef struct {
    op_t op;
    int  h, m, s, md, bh, bm;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int h, input int m, input int s,
                         input int md, input int bh, input int bm);
    chk({tag, " hours"},     int'(hours),     h);
    chk({tag, " minutes"},   int'(minutes),   m);
    chk({tag, " seconds"},   int'(seconds),   s);
    chk({tag, " mode"},      int'(mode),      md);
    chk({tag, " blank_hr"},  int'(blank_hr),  bh);
    chk({tag, " blank_min"}, int'(blank_min), bm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1();  i_clk1  = 1'b1; step(); i_clk1  = 1'b0; step(); endtask
  task automatic pulse4();  i_clk4  = 1'b1; step(); i_clk4  = 1'b0; step(); endtask
  task automatic pulse64(); i_clk64 = 1'b1; step(); i_clk64 = 1'b0; step(); endtask
  task automatic press_mode(); btn_mode = 1'b1; step(); btn_mode = 1'b0; step(); endtask
  task automatic press_inc();  btn_inc  = 1'b1; step(); btn_inc  = 1'b0; step(); endtask

  // Reset asserted and released between clock edges.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk_all(tag, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    step();
  endtask

  initial begin
    int wraps;
    int exp_m;

    // Set-sequence vectors, starting in RUN at 00:00:37 with blink phase 0.
    tbl[0]  = '{OP_MODE, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{OP_INC,  1, 0, 0, 1, 0, 0};
    tbl[2]  = '{OP_INC,  2, 0, 0, 1, 0, 0};
    tbl[3]  = '{OP_INC,  3, 0, 0, 1, 0, 0};
    tbl[4]  = '{OP_MODE, 3, 0, 0, 2, 0, 0};
    tbl[5]  = '{OP_INC,  3, 1, 0, 2, 0, 0};
    tbl[6]  = '{OP_INC,  3, 2, 0, 2, 0, 0};
    tbl[7]  = '{OP_MODE, 3, 2, 0, 0, 0, 0};
    tbl[8]  = '{OP_T1,   3, 2, 1, 0, 0, 0};
    tbl[9]  = '{OP_T1,   3, 2, 2, 0, 0, 0};
    tbl[10] = '{OP_T4,   3, 2, 2, 0, 0, 0};
    tbl[11] = '{OP_T4,   3, 2, 2, 0, 0, 0};

    // Reset with i_clk1 and btn_mode held high through release.
    rst = 1'b1;
    i_clk1 = 1'b1; i_clk4 = 1'b0; i_clk64 = 1'b0;
    btn_mode = 1'b1; btn_inc = 1'b0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) step();
    chk_all("held_through_reset", 0, 0, 0, 0, 0, 0);
    i_clk1 = 1'b0; btn_mode = 1'b0;
    step();

    // Reset mid-run at 00:00:05.
    repeat (5) pulse1();
    chk("run seconds", int'(seconds), 5);
    async_reset("reset_mid_run");

    // Reset while in SET_HR.
    press_mode();
    press_inc();
    chk("set_hr mode", int'(mode), 1);
    chk("set_hr hours", int'(hours), 1);
    async_reset("reset_in_set");

    // Set sequence from 00:00:37.
    repeat (37) pulse1();
    chk("seconds 37", int'(seconds), 37);
    for (int i = 0; i < 12; i++) begin
      case (tbl[i].op)
        OP_T1:   pulse1();
        OP_T4:   pulse4();
        OP_MODE: press_mode();
        default: press_inc();
      endcase
      chk_all($sformatf("vec%0d", i), tbl[i].h, tbl[i].m, tbl[i].s,
              tbl[i].md, tbl[i].bh, tbl[i].bm);
    end

    // Preload 23:59 and roll over through 60 seconds.
    press_mode();
    repeat (20) press_inc();
    press_mode();
    repeat (57) press_inc();
    press_mode();
    chk_all("preload", 23, 59, 0, 0, 0, 0);
    wraps = 0;
    for (int k = 1; k <= 60; k++) begin
      pulse1();
      if (hours == 5'd0) wraps++;
      chk($sformatf("roll%0d hours", k), int'(hours), (k == 60) ? 0 : 23);
      chk($sformatf("roll%0d minutes", k), int'(minutes), (k == 60) ? 0 : 59);
      chk($sformatf("roll%0d seconds", k), int'(seconds), k % 60);
    end
    chk("hour wraps", wraps, 1);

    // Auto-repeat in SET_MIN from 58.
    press_mode();
    press_mode();
    repeat (58) press_inc();
    chk("rep start minutes", int'(minutes), 58);
    btn_inc = 1'b1;
    step();
    chk("rep press minutes", int'(minutes), 59);
    repeat (4) pulse4();
    chk("rep hold minutes", int'(minutes), 59);
    chk("rep hold blank_min", int'(blank_min), 0);
    for (int k = 1; k <= 16; k++) begin
      pulse64();
      exp_m = (k < 8) ? 59 : ((k < 16) ? 0 : 1);
      chk($sformatf("rep%0d minutes", k), int'(minutes), exp_m);
      chk($sformatf("rep%0d hours", k), int'(hours), 0);
    end
    btn_inc = 1'b0;
    step();
    repeat (8) pulse64();
    chk("rep release minutes", int'(minutes), 1);

    // Blink in SET_HR.
    press_mode();
    press_mode();
    chk_all("blink entry", 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      pulse4();
      chk($sformatf("blink%0d blank_hr", k), int'(blank_hr), k % 2);
      chk($sformatf("blink%0d blank_min", k), int'(blank_min), 0);
    end
    btn_inc = 1'b1;
    step();
    chk("blink held blank_hr", int'(blank_hr), 0);
    chk("blink held hours", int'(hours), 1);
    btn_inc = 1'b0;
    step();
    chk("blink released blank_hr", int'(blank_hr), 1);

    // Mode and inc pressed together in SET_HR.
    btn_mode = 1'b1; btn_inc = 1'b1;
    step();
    btn_mode = 1'b0; btn_inc = 1'b0;
    step();
    chk_all("mode+inc", 1, 1, 0, 2, 0, 1);

    // Mode press coincident with tick1 in RUN at seconds 20.
    press_mode();
    repeat (20) pulse1();
    chk("seconds 20", int'(seconds), 20);
    btn_mode = 1'b1; i_clk1 = 1'b1;
    step();
    chk("mode+tick1 mode", int'(mode), 1);
    chk("mode+tick1 seconds", int'(seconds), 0);
    btn_mode = 1'b0; i_clk1 = 1'b0;
    step();

    // SET_MIN -> RUN coincident with tick1: tick dropped, next tick counts.
    press_mode();
    btn_mode = 1'b1; i_clk1 = 1'b1;
    step();
    chk("exit+tick1 mode", int'(mode), 0);
    chk("exit+tick1 seconds", int'(seconds), 0);
    btn_mode = 1'b0; i_clk1 = 1'b0;
    step();
    pulse1();
    chk("resume seconds", int'(seconds), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Timekeeping and time-set controller for the digital clock. Consumes the divider's 1 Hz, 4 Hz and 64 Hz square-wave outputs and converts their rising edges into single-cycle ticks. Sequences the hours/minutes/seconds counters through a RUN / SET_HR / SET_MIN state machine driven by two debounced buttons. Drives the display path with binary time fields plus blink-blanking enables.

## Interface
- `HOLD_TICKS`, default 4: number of 4 Hz ticks that `btn_inc` must stay high before auto-repeat starts.
- `REPEAT_DIV`, default 8: number of 64 Hz ticks between auto-repeat increments, giving 8 increments/s.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `i_clk1` in 1: 1 Hz square wave from the divider.
- `i_clk4` in 1: 4 Hz square wave from the divider.
- `i_clk64` in 1: 64 Hz square wave from the divider.
- `btn_mode` in 1: mode button; already debounced and synchronous to `clk`; level input.
- `btn_inc` in 1: increment button; already debounced and synchronous to `clk`; level input.
- `hours` out 5: 0–23, binary.
- `minutes` out 6: 0–59, binary.
- `seconds` out 6: 0–59, binary.
- `mode` out 2: 00 = RUN, 01 = SET_HR, 10 = SET_MIN. Value 11 is never driven.
- `blank_hr` out 1: when high, the display blanks the hour digits.
- `blank_min` out 1: when high, the display blanks the minute digits.

## Operation
- **Edge detection:**
  - Each square-wave input and each button is registered once.
  - tickN = iN & ~iN_d.
  - press = btn & ~btn_d.
- **RUN:**
  - On tick1: `seconds`+1.
  - At 59: `seconds`→0 and `minutes`+1.
  - `minutes` 59→0 carries into `hours`+1.
  - `hours` 23→0.
- **Mode transitions:**
  - Each mode press moves the state RUN→SET_HR→SET_MIN→RUN.
  - Entering SET_HR clears `seconds` to 0.
  - While in either SET state, `seconds` is frozen and tick1 is ignored.
- **Increment in SET states:**
  - An inc press increments the selected field by 1: `hours` in SET_HR, `minutes` in SET_MIN.
  - Wrap without carry: `hours` 23→0, `minutes` 59→0.
- **Auto-repeat:**
  - `hold_cnt` counts tick4 while `btn_inc` is high, saturating at HOLD_TICKS.
  - `hold_cnt` clears when `btn_inc` is low or on any mode press.
  - Once saturated, `rep_cnt` counts tick64.
  - Each time `rep_cnt` reaches REPEAT_DIV-1, `rep_cnt`→0 and the selected field increments once.
- **Blink:**
  - `blink_ph` toggles on every tick4, giving a 2 Hz blink.
  - `blank_hr` = (SET_HR) & `blink_ph` & ~`btn_inc`.
  - `blank_min` = (SET_MIN) & `blink_ph` & ~`btn_inc`.
  - Digits are shown steadily while the increment button is held.
  - Both blank outputs are 0 in RUN.
- **Priorities within one cycle:**
  - Mode press beats inc press; the inc press is dropped.
  - In RUN, a mode press and tick1 in the same cycle: the state goes to SET_HR and `seconds` = 0. The clear wins and the tick is lost.
  - A mode press from SET_MIN to RUN in the same cycle as tick1: the tick is ignored. Counting resumes at the next tick1.
- **Leaving auto-repeat:**
  - Releasing `btn_inc` stops auto-repeat immediately.
  - No further increments occur after the cycle in which `btn_inc` is sampled low.

## Timing
- **Reset values (`rst` high, any time, asynchronous):**
  - `hours` = `minutes` = `seconds` = 0.
  - `mode` = 00 (RUN).
  - `blank_hr` = `blank_min` = 0.
  - All edge-detect registers, `hold_cnt`, `rep_cnt` and `blink_ph` = 0.
- **Reset mid-operation:**
  - A reset during SET or during auto-repeat returns to RUN at 00:00:00.
  - An input held high through reset release does not produce a tick or press, because the `_d` register captures it on the first clock.
  - Consequence: the first tick after release needs a new low→high transition.
- **Latency:** an input first sampled high at edge k updates the registered outputs at edge k. They are visible after that edge, i.e. 1 cycle after the input rises.
- **Blank outputs:** combinational from registered state, `blink_ph` and `btn_inc`.
- **No cross-clock logic:** every input is synchronous to `clk`.

## Test plan
- **Reset mid-run:** run to 00:00:05, then assert `rst` for 1 cycle asynchronously between edges → all outputs 0 immediately; `mode` = 00.
- **Rollover:**
  - Preload via set mode to 23:59, return to RUN, apply 60 × i_clk1 rising edges → 00:00:00 on the last edge.
  - Expect exactly one `hours` wrap and no intermediate illegal values.
- **Set sequence:**
  - In RUN at 00:00:37, press mode → `mode` = 01 and `seconds` = 0.
  - 3 inc presses → `hours` = 3.
  - Press mode → 10; 2 inc presses → `minutes` = 2.
  - Press mode → 00. Further i_clk1 ticks advance `seconds` from 0.
- **Auto-repeat:**
  - In SET_MIN at `minutes` = 58, hold `btn_inc` through 4 tick4 and then 16 tick64 → initial press plus 2 repeats.
  - Expected `minutes` sequence: 59, 0, 1, with no `hours` change.
- **Blink:**
  - In SET_HR with `btn_inc` low, `blank_hr` toggles on each tick4 and `blank_min` stays 0.
  - Holding `btn_inc` forces `blank_hr` to 0.
- **Simultaneous events:**
  - Mode press and inc press in the same cycle in SET_HR → `mode` = 10 and `hours` unchanged.
  - Mode press coincident with tick1 in RUN at `seconds` = 20 → `mode` = 01 and `seconds` = 0.
